fxm_bcd_display: RTL and testbench

//  Downstream consumer of the frequency meter's 16-bit count (Mes_FXM.FXM).
//  - Converts each new count to BCD with a sequential shift-add-3 (double-dabble) FSM.
//  - Drives a 4-digit multiplexed 7-segment display (AN/seg/seg_P) scanned by a 1 ms ce.
//  - Values above 9999 are flagged and shown as "----".

---
 rtl/fxm_bcd_display.sv | 199 +++++++++++++++++++
 tb/tb_fxm_bcd_display.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fxm_bcd_display.sv
// fxm_bcd_display: converts the frequency meter's 16-bit count to five BCD
// digits with a sequential shift-add-3 converter and scans the low four digits
// onto a multiplexed, active-low 7-segment display.
// Optional build macro: FXM_DISP_LZ_BLANK_EN (blank leading zeros on the display).
module fxm_bcd_display #(
    parameter int DP_POS   = 4,   // digit whose decimal point is lit; 4 = none
    parameter int SCAN_DIV = 1    // ce1ms strobes per digit step (>= 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce1ms,
    input  logic        load,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic        ovf,
    output logic [3:0]  AN,
    output logic [6:0]  seg,
    output logic        seg_P
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state, w_state_next;
    logic [15:0]   r_sh, w_sh_next;
    logic [19:0]   r_scr, w_scr_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [19:0]   r_bcd, w_bcd_next;
    logic          r_ovf, w_ovf_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic [1:0]    r_idx, w_idx_next;
    logic [3:0]    r_an, w_an_next;
    logic [6:0]    r_seg, w_seg_next;
    logic          r_dp, w_dp_next;

    logic [19:0]   w_adj;
    logic [35:0]   w_shifted;
    logic [3:0]    w_digit;
    logic          w_blank;

    // 7-segment pattern {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction on every scratch nibble that would overflow a BCD digit
    // when doubled by the following shift.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_scr[gi*4 +: 4] >= 4'd5) ? (r_scr[gi*4 +: 4] + 4'd3)
                                                                 : r_scr[gi*4 +: 4];
        end
    endgenerate

    assign w_shifted = {w_adj, r_sh} << 1;

    // Converter next-state and result capture; the result is taken from the
    // 16th shift directly so done and the new bcd appear in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_sh_next    = r_sh;
        w_scr_next   = r_scr;
        w_cnt_next   = r_cnt;
        w_bcd_next   = r_bcd;
        w_ovf_next   = r_ovf;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (load) begin
                    w_sh_next    = din;
                    w_scr_next   = 20'd0;
                    w_cnt_next   = 4'd0;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_scr_next = w_shifted[35:16];
                w_sh_next  = w_shifted[15:0];
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_next = S_DONE;
                    w_bcd_next   = w_shifted[35:16];
                    w_ovf_next   = |w_shifted[35:32];
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Scan prescaler and digit index
    always_comb begin
        w_presc_next = r_presc;
        w_idx_next   = r_idx;
        if (ce1ms) begin
            if (r_presc == PW'(SCAN_DIV - 1)) begin
                w_presc_next = '0;
                w_idx_next   = r_idx + 2'd1;
            end else begin
                w_presc_next = r_presc + PW'(1);
            end
        end
    end

`ifdef FXM_DISP_LZ_BLANK_EN
    logic [3:0] w_nz;
    logic [3:0] w_lead;
    // A digit is a leading zero when it and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lz
            assign w_nz[gi]   = |w_bcd_next[gi*4 +: 4];
            assign w_lead[gi] = ~|w_nz[3:gi];
        end
    endgenerate
    assign w_blank = w_lead[w_idx_next] && (w_idx_next != 2'd0) && (int'(w_idx_next) > DP_POS);
`else
    assign w_blank = 1'b0;
`endif

    // Display pattern built from next-cycle index and value so AN/seg/seg_P
    // always agree with the registered bcd and index.
    always_comb begin
        w_digit = 4'd0;
        case (w_idx_next)
            2'd0: w_digit = w_bcd_next[3:0];
            2'd1: w_digit = w_bcd_next[7:4];
            2'd2: w_digit = w_bcd_next[11:8];
            2'd3: w_digit = w_bcd_next[15:12];
            default: w_digit = 4'd0;
        endcase
        w_an_next = ~(4'b0001 << w_idx_next);
        if (w_ovf_next) begin
            w_seg_next = 7'b0111111;
        end else if (w_blank) begin
            w_seg_next = 7'b1111111;
        end else begin
            w_seg_next = seg7(w_digit);
        end
        w_dp_next = (int'(w_idx_next) == DP_POS) ? 1'b0 : 1'b1;
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= 16'd0;
            r_scr   <= 20'd0;
            r_cnt   <= 4'd0;
            r_bcd   <= 20'd0;
            r_ovf   <= 1'b0;
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_an    <= 4'b1110;
            r_seg   <= 7'b1000000;
            r_dp    <= (DP_POS == 0) ? 1'b0 : 1'b1;
        end else begin
            r_state <= w_state_next;
            r_sh    <= w_sh_next;
            r_scr   <= w_scr_next;
            r_cnt   <= w_cnt_next;
            r_bcd   <= w_bcd_next;
            r_ovf   <= w_ovf_next;
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
            r_dp    <= w_dp_next;
        end
    end

    assign busy  = (r_state == S_SHIFT);
    assign done  = (r_state == S_DONE);
    assign bcd   = r_bcd;
    assign ovf   = r_ovf;
    assign AN    = r_an;
    assign seg   = r_seg;
    assign seg_P = r_dp;

endmodule

// File: tb/tb_fxm_bcd_display.sv
// Bench for fxm_bcd_display: decimal-arithmetic reference model checked every
// cycle, plus directed literal checks of the documented scenarios.
module tb_fxm_bcd_display;

    localparam int DP  = 1;
    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst, ce1ms, load;
    logic [15:0] din;
    logic        busy, done, ovf, seg_P;
    logic [19:0] bcd;
    logic [3:0]  AN;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    // reference model state
    int m_val = 0, m_age = -1, m_pend = 0, m_str = 0;
    bit m_valid = 1'b0;

    fxm_bcd_display #(.DP_POS(DP), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .ce1ms(ce1ms), .load(load), .din(din),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf),
        .AN(AN), .seg(seg), .seg_P(seg_P)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        for (int k = 0; k < 5; k++) r[k*4 +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [34:0] expected();
        int          idx;
        logic [3:0]  one = 4'b0001;
        logic [3:0]  an;
        logic [6:0]  sg;
        logic        blank;
        idx   = (m_str / DIV) % 4;
        an    = ~(one << idx);
        blank = 1'b0;
`ifdef FXM_DISP_LZ_BLANK_EN
        blank = (idx > 0) && (idx > DP) && (m_val < pow10(idx));
`endif
        if (m_val > 9999)  sg = 7'b0111111;
        else if (blank)    sg = 7'b1111111;
        else               sg = seg_of((m_val / pow10(idx)) % 10);
        return {(m_age >= 0 && m_age <= 15), (m_age == 16), to_bcd(m_val),
                (m_val > 9999), an, sg, (idx == DP) ? 1'b0 : 1'b1};
    endfunction

    // Per-cycle compare against the model, then advance the model with the
    // inputs that the next rising edge will sample.
    initial begin
        logic [34:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_v = expected();
                act_v = {busy, done, bcd, ovf, AN, seg, seg_P};
                n_checks++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL cycle_cmp t=%0t got {busy,done,bcd,ovf,AN,seg,dp}=%h expected %h",
                              $time, act_v, exp_v);
                if (done === 1'b1) n_done++;
            end
            if (rst) begin
                m_val = 0; m_age = -1; m_str = 0; m_valid = 1'b1;
            end else begin
                if (ce1ms) m_str = (m_str + 1) % (4 * DIV);
                if (load && (m_age == -1 || m_age == 16)) begin
                    m_age = 0; m_pend = int'(din);
                end else if (m_age >= 0) begin
                    m_age++;
                    if (m_age == 16) m_val = m_pend;
                    if (m_age == 17) m_age = -1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", name, got, exp);
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] d, input logic c);
        @(posedge clk);
        #1;
        rst = r; load = l; din = d; ce1ms = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0, 1'b0);
        idle(1);
    endtask

    // load one value, wait (bounded) for done, check latency and busy width
    task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd, input logic exp_ovf);
        int lat = -1;
        int nb  = 0;
        step(1'b0, 1'b1, v, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            idle(1);
            if (busy === 1'b1) nb++;
            if (done === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
        chk("latency", lat, 16);
        chk("busy_cycles", nb, 16);
        chk("bcd", {12'd0, bcd}, {12'd0, exp_bcd});
        chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    task automatic scan_step();
        for (int i = 0; i < DIV; i++) step(1'b0, 1'b0, 16'd0, 1'b1);
        idle(1);
    endtask

    initial begin
        int d0;
        logic [15:0] rv;
        rst = 1'b1; load = 1'b0; din = 16'd0; ce1ms = 1'b0;

        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd", {12'd0, bcd}, 32'd0);
        chk("rst_AN", {28'd0, AN}, 32'h0000000E);
        chk("rst_seg", {25'd0, seg}, 32'h00000040);

        convert(16'd1234, 20'h01234, 1'b0);
        scan_step();
        chk("scan1_AN", {28'd0, AN}, 32'h0000000D);
        chk("scan1_seg", {25'd0, seg}, {25'd0, 7'b0110000});
        scan_step();
        chk("scan2_AN", {28'd0, AN}, 32'h0000000B);
        chk("scan2_seg", {25'd0, seg}, {25'd0, 7'b0100100});
        scan_step();
        chk("scan3_AN", {28'd0, AN}, 32'h00000007);
        chk("scan3_seg", {25'd0, seg}, {25'd0, 7'b1111001});
        scan_step();
        chk("scan0_AN", {28'd0, AN}, 32'h0000000E);
        chk("scan0_seg", {25'd0, seg}, {25'd0, 7'b0011001});

        convert(16'd9999, 20'h09999, 1'b0);
        convert(16'd10000, 20'h10000, 1'b1);
        chk("ovf_seg", {25'd0, seg}, {25'd0, 7'b0111111});

        // mid-conversion load must be dropped
        idle(2);
        d0 = n_done;
        step(1'b0, 1'b1, 16'd65535, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 16'd1, 1'b0);
        idle(30);
        chk("midload_dones", n_done - d0, 1);
        chk("midload_bcd", {12'd0, bcd}, 32'h00065535);
        chk("midload_ovf", {31'd0, ovf}, 32'd1);

        // reset during conversion aborts it
        d0 = n_done;
        step(1'b0, 1'b1, 16'd4321, 1'b0);
        idle(7);
        step(1'b1, 1'b0, 16'd0, 1'b0);
        idle(1);
        chk("abort_bcd", {12'd0, bcd}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        idle(25);
        chk("abort_nodone", n_done - d0, 0);
        convert(16'd4321, 20'h04321, 1'b0);

        // leading-zero behaviour on digit 3
        do_reset();
        convert(16'd7, 20'h00007, 1'b0);
        for (int i = 0; i < 3; i++) scan_step();
        chk("lz_AN3", {28'd0, AN}, 32'h00000007);
`ifdef FXM_DISP_LZ_BLANK_EN
        chk("lz_seg3", {25'd0, seg}, {25'd0, 7'b1111111});
`else
        chk("lz_seg3", {25'd0, seg}, {25'd0, 7'b1000000});
`endif
        scan_step();
        chk("lz_seg0", {25'd0, seg}, {25'd0, 7'b1111000});

        // randomized traffic; the per-cycle compare does the checking
        for (int i = 0; i < 4000; i++) begin
            rv = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 120)) : 16'($urandom);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0), rv,
                 ($urandom_range(0, 3) == 0));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
